// File: rtl/rx_frame_parser_pkg.sv
// -----------------------------------------------------------------------------
// rx_frame_parser_pkg
// Shared definitions for the received-frame parser:
//   - FSM state encoding (IDLE, LEN, PAYLOAD, CHECK, DRAIN)
//   - error codes reported on Err_Code (NONE, LEN, CHK, TMO)
//   - default parameter values (payload limit, start-of-frame byte, timeout)
//   - small helpers shared by the parser and its payload buffer
// -----------------------------------------------------------------------------
package rx_frame_parser_pkg;

    localparam int unsigned DEFAULT_MAX_LEN     = 8;
    localparam logic [7:0]  DEFAULT_HEADER      = 8'hAA;
    // 10 ms of inter-byte silence at 500 kHz
    localparam int unsigned DEFAULT_TIMEOUT_CYC = 5000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CHECK   = 3'd3,
        ST_DRAIN   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE = 2'b00,
        ERR_LEN  = 2'b01,
        ERR_CHK  = 2'b10,
        ERR_TMO  = 2'b11
    } err_t;

    // A length byte is acceptable when it names 1..max_len payload bytes.
    function automatic logic len_in_range(input logic [7:0] len, input int unsigned max_len);
        return (len != 8'd0) && (32'(len) <= max_len);
    endfunction

    // Address width for a buffer of the given depth (at least one bit).
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/rx_frame_buf.sv
// -----------------------------------------------------------------------------
// rx_frame_buf
// Payload store for one frame: DEPTH x 8 register file.
// Contents are not reset; the parser only reads locations it has written in
// the current frame.
// Ports:
//   CLK      in   clock
//   wr_en    in   write strobe (synchronous write)
//   wr_addr  in   write address
//   wr_data  in   write byte
//   rd_addr  in   read address (combinational read)
//   rd_data  out  byte at rd_addr
// -----------------------------------------------------------------------------
module rx_frame_buf #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              CLK,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    logic [7:0] word [DEPTH];

    // One register per entry with its own address decode.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [7:0] entry_reg;

        always_ff @(posedge CLK) begin
            if (wr_en && (wr_addr == ADDR_W'(gi))) begin
                entry_reg <= wr_data;
            end
        end

        assign word[gi] = entry_reg;
    end

    // Addresses past the last entry (non power-of-two depth) read as zero.
    assign rd_data = (32'(rd_addr) < DEPTH) ? word[rd_addr] : 8'h00;

endmodule

// File: rtl/rx_frame_parser.sv
// -----------------------------------------------------------------------------
// rx_frame_parser
// Byte-level frame parser behind the UART receiver (500 kHz domain).
// Frame on the wire: HEADER, LEN, LEN payload bytes, CHK where
// CHK = (LEN + sum of payload) mod 256. The payload is buffered, and only a
// frame with a legal LEN and a matching CHK is replayed on the valid/ready
// output stream. Rejected frames raise Frame_Err with a code on Err_Code.
//
// Optional build macro:
//   RX_FRAME_TIMEOUT_EN  - abort a frame (code 11) after TIMEOUT_CYC clocks
//                          without a byte while inside LEN/PAYLOAD/CHECK.
//                          Without it the parser waits indefinitely mid-frame.
//
// Ports:
//   CLK          in   clock
//   RSTn         in   asynchronous reset, active low
//   RX_Data      in   received byte, valid on the rising edge of RX_Done_Sig
//   RX_Done_Sig  in   byte-done strobe (may stay high for several cycles)
//   Out_Data     out  payload byte
//   Out_Valid    out  Out_Data valid
//   Out_Ready    in   consumer accepts on Out_Valid & Out_Ready
//   Out_Last     out  last payload byte of the frame
//   Frame_Ok     out  one-cycle pulse, frame verified
//   Frame_Err    out  one-cycle pulse, frame rejected
//   Err_Code     out  01 length, 10 checksum, 11 timeout; 00 after Frame_Ok
//   Busy         out  parser not idle
// -----------------------------------------------------------------------------
module rx_frame_parser
    import rx_frame_parser_pkg::*;
#(
    parameter int unsigned MAX_LEN     = DEFAULT_MAX_LEN,
    parameter logic [7:0]  HEADER      = DEFAULT_HEADER,
    parameter int unsigned TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic [7:0] RX_Data,
    input  logic       RX_Done_Sig,
    output logic [7:0] Out_Data,
    output logic       Out_Valid,
    input  logic       Out_Ready,
    output logic       Out_Last,
    output logic       Frame_Ok,
    output logic       Frame_Err,
    output logic [1:0] Err_Code,
    output logic       Busy
);

    localparam int unsigned PTR_W = ptr_width(MAX_LEN);

    // Parameter sanity: LEN is a byte, and the timeout needs at least 2 cycles.
    if (MAX_LEN < 1 || MAX_LEN > 255) begin : g_bad_max_len
        $error("rx_frame_parser: MAX_LEN must be in 1..255");
    end
    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("rx_frame_parser: TIMEOUT_CYC must be at least 2");
    end

    state_t           state_reg;
    logic             done_q_reg;
    logic [PTR_W-1:0] wr_cnt_reg;
    logic [PTR_W-1:0] rd_cnt_reg;
    logic [PTR_W-1:0] len_last_reg;   // LEN-1, index of the final payload byte
    logic [7:0]       sum_reg;
    logic             out_valid_reg;
    logic             frame_ok_reg;
    logic             frame_err_reg;
    err_t             err_code_reg;

    logic             byte_ev;
    logic             handshake;
    logic             wr_at_last;
    logic             rd_at_last;
    logic             tmo_hit;
    logic             buf_wr_en;
    logic [7:0]       buf_rd_data;

    // A strobe held high for several cycles yields exactly one byte event.
    assign byte_ev    = RX_Done_Sig && !done_q_reg;
    assign handshake  = out_valid_reg && Out_Ready;
    assign wr_at_last = (wr_cnt_reg == len_last_reg);
    assign rd_at_last = (rd_cnt_reg == len_last_reg);
    assign buf_wr_en  = byte_ev && (state_reg == ST_PAYLOAD);

    // -------------------------------------------------------------------------
    // Inter-byte timeout
    // -------------------------------------------------------------------------
`ifdef RX_FRAME_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] tmo_cnt_reg;
    logic             in_frame;

    assign in_frame = (state_reg == ST_LEN) || (state_reg == ST_PAYLOAD) ||
                      (state_reg == ST_CHECK);

    // Fires on the cycle whose edge would bring the count to TIMEOUT_CYC.
    // A byte arriving in that same cycle wins.
    assign tmo_hit = in_frame && !byte_ev && (tmo_cnt_reg == TMO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            tmo_cnt_reg <= '0;
        end else if (!in_frame || byte_ev) begin
            tmo_cnt_reg <= '0;
        end else begin
            tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Payload buffer
    // -------------------------------------------------------------------------
    rx_frame_buf #(
        .DEPTH  (MAX_LEN),
        .ADDR_W (PTR_W)
    ) u_buf (
        .CLK     (CLK),
        .wr_en   (buf_wr_en),
        .wr_addr (wr_cnt_reg),
        .wr_data (RX_Data),
        .rd_addr (rd_cnt_reg),
        .rd_data (buf_rd_data)
    );

    // -------------------------------------------------------------------------
    // Frame FSM, checksum and drain pointer
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_reg     <= ST_IDLE;
            done_q_reg    <= 1'b0;
            wr_cnt_reg    <= '0;
            rd_cnt_reg    <= '0;
            len_last_reg  <= '0;
            sum_reg       <= 8'h00;
            out_valid_reg <= 1'b0;
            frame_ok_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            err_code_reg  <= ERR_NONE;
        end else begin
            done_q_reg    <= RX_Done_Sig;
            frame_ok_reg  <= 1'b0;
            frame_err_reg <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (byte_ev && (RX_Data == HEADER)) begin
                        state_reg <= ST_LEN;
                    end
                end

                ST_LEN: begin
                    if (byte_ev) begin
                        if (len_in_range(RX_Data, MAX_LEN)) begin
                            len_last_reg <= PTR_W'(RX_Data - 8'd1);
                            sum_reg      <= RX_Data;   // LEN is part of the checksum
                            wr_cnt_reg   <= '0;
                            state_reg    <= ST_PAYLOAD;
                        end else begin
                            frame_err_reg <= 1'b1;
                            err_code_reg  <= ERR_LEN;
                            state_reg     <= ST_IDLE;
                        end
                    end else if (tmo_hit) begin
                        frame_err_reg <= 1'b1;
                        err_code_reg  <= ERR_TMO;
                        state_reg     <= ST_IDLE;
                    end
                end

                ST_PAYLOAD: begin
                    if (byte_ev) begin
                        sum_reg    <= sum_reg + RX_Data;
                        wr_cnt_reg <= wr_cnt_reg + PTR_W'(1);
                        if (wr_at_last) begin
                            state_reg <= ST_CHECK;
                        end
                    end else if (tmo_hit) begin
                        frame_err_reg <= 1'b1;
                        err_code_reg  <= ERR_TMO;
                        state_reg     <= ST_IDLE;
                    end
                end

                ST_CHECK: begin
                    if (byte_ev) begin
                        if (RX_Data == sum_reg) begin
                            frame_ok_reg  <= 1'b1;
                            err_code_reg  <= ERR_NONE;
                            rd_cnt_reg    <= '0;
                            out_valid_reg <= 1'b1;
                            state_reg     <= ST_DRAIN;
                        end else begin
                            frame_err_reg <= 1'b1;
                            err_code_reg  <= ERR_CHK;
                            state_reg     <= ST_IDLE;
                        end
                    end else if (tmo_hit) begin
                        frame_err_reg <= 1'b1;
                        err_code_reg  <= ERR_TMO;
                        state_reg     <= ST_IDLE;
                    end
                end

                // Incoming bytes are ignored here; header search restarts in IDLE.
                ST_DRAIN: begin
                    if (handshake) begin
                        if (rd_at_last) begin
                            out_valid_reg <= 1'b0;
                            rd_cnt_reg    <= '0;
                            state_reg     <= ST_IDLE;
                        end else begin
                            rd_cnt_reg <= rd_cnt_reg + PTR_W'(1);
                        end
                    end
                end

                default: begin
                    out_valid_reg <= 1'b0;
                    state_reg     <= ST_IDLE;
                end
            endcase
        end
    end

    // Data/last follow the registered read pointer, so they hold steady while
    // a byte is stalled. Gating with valid keeps the unreset buffer contents
    // off the port outside a drain.
    assign Out_Data  = out_valid_reg ? buf_rd_data : 8'h00;
    assign Out_Valid = out_valid_reg;
    assign Out_Last  = out_valid_reg && rd_at_last;
    assign Frame_Ok  = frame_ok_reg;
    assign Frame_Err = frame_err_reg;
    assign Err_Code  = err_code_reg;
    assign Busy      = (state_reg != ST_IDLE);

endmodule
